// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / hazard control block.
// Optional load-use stall counter is enabled by defining FWD_STALL_CNT_EN.
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;
  localparam logic [1:0] FWD_SEL_ZERO  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rs;
    logic [REG_AW_DEF-1:0] rt;
    logic                  uses_rt;
    logic [REG_AW_DEF-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] dest;
    logic                  reg_write;
  } wb_slot_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Per-operand forwarding select: $0 forces zero, then newest
// in-flight writer (MEM) beats the older one (WB).
module fwd_sel_logic
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic          ex_valid,
  input  logic [AW-1:0] src,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] mem_dest,
  input  logic          wb_valid,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_dest,
  output logic [1:0]    sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_valid && mem_reg_write && (mem_dest == src);
    wb_hit  = wb_valid && wb_reg_write && (wb_dest == src);
    sel     = FWD_SEL_RF;
    if (!ex_valid)
      sel = FWD_SEL_RF;
    else if (src == '0)
      sel = FWD_SEL_ZERO;
    else if (mem_hit)
      sel = FWD_SEL_EXMEM;
    else if (wb_hit)
      sel = FWD_SEL_MEMWB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-mux selects and load-use stall for the 5-stage pipeline.
// Define FWD_STALL_CNT_EN to add the stall_count port and counter.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q, wb_d;

  logic load_use;
  logic unused_fields;

  assign unused_fields = ^{mem_q.mem_read, ex_q.uses_rt};

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.mem_read
               && (ex_q.dest != '0)
               && ((ex_q.dest == id_rs)
                   || (id_uses_rt && (ex_q.dest == id_rt)));
    // A flushed ID instruction never reaches EX, so it cannot stall.
    stall = load_use && !flush;
  end

  always_comb begin
    ex_d = '0;
    if (!(rst || flush || stall)) begin
      ex_d.valid     = id_valid;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.uses_rt   = id_uses_rt;
      ex_d.dest      = id_dest;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
    mem_d.valid     = ex_q.valid;
    mem_d.dest      = ex_q.dest;
    mem_d.reg_write = ex_q.reg_write;
    mem_d.mem_read  = ex_q.mem_read;
    wb_d.valid      = mem_q.valid;
    wb_d.dest       = mem_q.dest;
    wb_d.reg_write  = mem_q.reg_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_sel_logic #(.AW(REG_AW)) u_sel_a (
    .ex_valid      (ex_q.valid),
    .src           (ex_q.rs),
    .mem_valid     (mem_q.valid),
    .mem_reg_write (mem_q.reg_write),
    .mem_dest      (mem_q.dest),
    .wb_valid      (wb_q.valid),
    .wb_reg_write  (wb_q.reg_write),
    .wb_dest       (wb_q.dest),
    .sel           (fwd_a_sel)
  );

  fwd_sel_logic #(.AW(REG_AW)) u_sel_b (
    .ex_valid      (ex_q.valid),
    .src           (ex_q.rt),
    .mem_valid     (mem_q.valid),
    .mem_reg_write (mem_q.reg_write),
    .mem_dest      (mem_q.dest),
    .wb_valid      (wb_q.valid),
    .wb_reg_write  (wb_q.reg_write),
    .wb_dest       (wb_q.dest),
    .sel           (fwd_b_sel)
  );

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count_q <= '0;
    else
      stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule
